// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment codes, FSM states and sizing helpers for the BCD display
package seg7_pkg;

  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
  };
  localparam logic [7:0] SEG_DASH = 8'h40;
  localparam logic [7:0] SEG_OFF  = 8'h00;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  // ceil(bin_width * log10(2)) in fixed point; the product is never an exact integer
  function automatic int acc_digits(input int bin_width);
    return (bin_width * 30103 + 99999) / 100000;
  endfunction

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// rtl/seg7_digit_decode.sv - one BCD digit to segment byte, with blank/dash override and polarity
module seg7_digit_decode
  import seg7_pkg::*;
#(
  parameter bit LOW_ACTIVE = 1'b1
) (
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       dash,
  output logic [7:0] seg
);

  logic [7:0] raw;

  always_comb begin
    raw = SEG_OFF;
    if (dash)               raw = SEG_DASH;
    else if (blank)         raw = SEG_OFF;
    else if (bcd <= 4'd9)   raw = SEG_DIGIT[bcd];
    seg = LOW_ACTIVE ? ~raw : raw;
  end

endmodule

// File: rtl/seg7_bcd_display.sv
// rtl/seg7_bcd_display.sv - bus-mapped binary to BCD converter (double dabble) driving 7-seg digits
module seg7_bcd_display
  import seg7_pkg::*;
#(
  parameter int BIN_WIDTH  = 16,
  parameter int DIGITS     = 5,
  parameter int ADDR_WIDTH = 3,
  parameter bit LOW_ACTIVE = 1'b1
) (
  input  logic                  s_clk,
  input  logic                  s_reset_n,
  input  logic [ADDR_WIDTH-1:0] s_address,
  input  logic                  s_write,
  input  logic [BIN_WIDTH-1:0]  s_writedata,
  input  logic                  s_read,
  output logic [7:0]            s_readdata,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [DIGITS*8-1:0]   SEG7
);

  localparam int ACC_RAW    = acc_digits(BIN_WIDTH);
  localparam int ACC_DIGITS = (ACC_RAW > DIGITS) ? ACC_RAW : DIGITS;
  localparam int ACC_W      = ACC_DIGITS * 4;
  localparam int CNT_W      = $clog2(BIN_WIDTH + 1);
  localparam logic [63:0] MAX_SHOWN = pow10(DIGITS) - 64'd1;

  state_t                 state_q, state_d;
  logic [BIN_WIDTH-1:0]   shift_q, shift_nx, pend_q, load_val;
  logic [ACC_W-1:0]       acc_q, acc_adj, acc_nx;
  logic [CNT_W-1:0]       cnt_q;
  logic                   ovf_pend_q, pend_valid_q, load;
  logic [DIGITS*4-1:0]    disp_q;
  logic                   overflow_q, done_q, blank_en_q;
  logic [7:0]             readdata_q, rd_mux;
  logic [DIGITS-1:0]      blank_vec;
  logic                   above_zero;
  logic                   wr_val, wr_cfg;

  assign wr_val = s_write && (s_address == '0);
  assign wr_cfg = s_write && (s_address == ADDR_WIDTH'(1));
  assign busy   = (state_q != IDLE);

  // LATCH prefers a write arriving in the same cycle over the pending one: latest wins
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = s_writedata;
    unique case (state_q)
      IDLE: if (wr_val) begin
        load    = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: if (cnt_q == CNT_W'(1)) state_d = LATCH;
      LATCH: begin
        state_d = IDLE;
        if (wr_val) begin
          load    = 1'b1;
          state_d = SHIFT;
        end else if (pend_valid_q) begin
          load     = 1'b1;
          load_val = pend_q;
          state_d  = SHIFT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < ACC_DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    {acc_nx, shift_nx} = {acc_adj, shift_q} << 1;
  end

  always_ff @(posedge s_clk) begin
    if (!s_reset_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      ovf_pend_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
      disp_q       <= '0;
      overflow_q   <= 1'b0;
      done_q       <= 1'b0;
      blank_en_q   <= 1'b1;
      readdata_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (wr_cfg) blank_en_q <= s_writedata[0];
      if (load) begin
        shift_q    <= load_val;
        acc_q      <= '0;
        cnt_q      <= CNT_W'(BIN_WIDTH);
        ovf_pend_q <= (64'(load_val) > MAX_SHOWN);
      end else if (state_q == SHIFT) begin
        shift_q <= shift_nx;
        acc_q   <= acc_nx;
        cnt_q   <= cnt_q - 1'b1;
      end
      if (state_q == LATCH) begin
        disp_q     <= acc_q[DIGITS*4-1:0];
        overflow_q <= ovf_pend_q;
        done_q     <= 1'b1;
      end
      if (wr_val && state_q == SHIFT) begin
        pend_valid_q <= 1'b1;
        pend_q       <= s_writedata;
      end else if (state_q == LATCH) begin
        pend_valid_q <= 1'b0;
      end
      if (s_read && !s_write) readdata_q <= rd_mux;
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (s_address == ADDR_WIDTH'(k)) rd_mux = {4'h0, disp_q[4*k +: 4]};
    end
    if (s_address == ADDR_WIDTH'(DIGITS)) rd_mux = {5'b0, overflow_q, busy, blank_en_q};
  end

  // a digit blanks only if it and every digit above it are zero; digit 0 always shows
  always_comb begin
    blank_vec  = '0;
    above_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      above_zero   = above_zero && (disp_q[4*k +: 4] == 4'd0);
      blank_vec[k] = blank_en_q && above_zero;
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    seg7_digit_decode #(.LOW_ACTIVE(LOW_ACTIVE)) u_dec (
      .bcd   (disp_q[4*k +: 4]),
      .blank (blank_vec[k]),
      .dash  (overflow_q),
      .seg   (SEG7[8*k +: 8])
    );
  end

  assign s_readdata = readdata_q;
  assign done       = done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_seg7_bcd_display.sv
// tb/tb_seg7_bcd_display.sv - bench for seg7_bcd_display (5-digit and 4-digit instances)
module tb_seg7_bcd_display;

  localparam int BW = 16;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, wr, rd;
  logic [2:0]  addr;
  logic [15:0] wdata;
  logic [7:0]  rdata1, rdata2;
  logic        busy1, busy2, done1, done2, ovf1, ovf2;
  logic [39:0] seg1;
  logic [31:0] seg2;

  seg7_bcd_display #(.BIN_WIDTH(16), .DIGITS(5), .ADDR_WIDTH(3), .LOW_ACTIVE(1'b1)) dut5 (
    .s_clk(clk), .s_reset_n(rst_n), .s_address(addr), .s_write(wr), .s_writedata(wdata),
    .s_read(rd), .s_readdata(rdata1), .busy(busy1), .done(done1), .overflow(ovf1), .SEG7(seg1)
  );

  seg7_bcd_display #(.BIN_WIDTH(16), .DIGITS(4), .ADDR_WIDTH(3), .LOW_ACTIVE(1'b1)) dut4 (
    .s_clk(clk), .s_reset_n(rst_n), .s_address(addr), .s_write(wr), .s_writedata(wdata),
    .s_read(rd), .s_readdata(rdata2), .busy(busy2), .done(done2), .overflow(ovf2), .SEG7(seg2)
  );

  logic [7:0] tbl [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;
  bit checking = 0;
  int t_wr;

  int  m_left, m_inflight, m_pend, m_disp;
  bit  m_pend_v, m_blank, m_done;
  logic [7:0] m_rd1, m_rd2;

  int         done_cyc [$];
  logic [39:0] done_seg [$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  function automatic longint p10(input int k);
    longint r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  function automatic int digit_of(input int v, input int k);
    return int'((longint'(v) / p10(k)) % 10);
  endfunction

  function automatic bit m_ovf(input int d);
    return longint'(m_disp) > p10(d) - 1;
  endfunction

  function automatic logic [63:0] exp_seg(input int v, input int d, input bit blank_en);
    logic [63:0] r;
    logic [7:0]  b;
    r = '0;
    for (int k = 0; k < d; k++) begin
      if (longint'(v) > p10(d) - 1)                    b = 8'h40;
      else if (blank_en && k > 0 && longint'(v) < p10(k)) b = 8'h00;
      else                                              b = tbl[digit_of(v, k)];
      r[8*k +: 8] = ~b;
    end
    return r;
  endfunction

  function automatic logic [7:0] exp_rd(input int a, input int d);
    if (a < d)  return {4'h0, 4'(digit_of(m_disp, a))};
    if (a == d) return {5'b0, m_ovf(d), (m_left > 0), m_blank};
    return 8'h00;
  endfunction

  // transaction-level model: a value written from idle is displayed BW+2 cycles later
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_left = 0; m_pend_v = 0; m_disp = 0; m_blank = 1; m_done = 0;
      m_rd1 = 8'h00; m_rd2 = 8'h00;
    end else begin
      if (rd && !wr) begin
        m_rd1 = exp_rd(int'(addr), 5);
        m_rd2 = exp_rd(int'(addr), 4);
      end
      m_done = 0;
      if (wr && addr == 3'd1) m_blank = wdata[0];
      if (m_left == 0) begin
        if (wr && addr == 3'd0) begin m_inflight = int'(wdata); m_left = BW + 1; end
      end else if (m_left == 1) begin
        m_disp = m_inflight; m_done = 1; m_left = 0;
        if (wr && addr == 3'd0) begin
          m_inflight = int'(wdata); m_left = BW + 1;
        end else if (m_pend_v) begin
          m_inflight = m_pend; m_left = BW + 1;
        end
        m_pend_v = 0;
      end else begin
        if (wr && addr == 3'd0) begin m_pend = int'(wdata); m_pend_v = 1; end
        m_left--;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("seg7_d5", 64'(seg1), exp_seg(m_disp, 5, m_blank));
      chk("seg7_d4", 64'(seg2), exp_seg(m_disp, 4, m_blank));
      chk("busy", 64'({busy1, busy2}), 64'({2{m_left > 0}}));
      chk("done", 64'({done1, done2}), 64'({2{m_done}}));
      chk("overflow", 64'({ovf1, ovf2}), 64'({m_ovf(5), m_ovf(4)}));
      chk("readdata", 64'({rdata1, rdata2}), 64'({m_rd1, m_rd2}));
      if (done1) begin
        done_cyc.push_back(cyc);
        done_seg.push_back(seg1);
      end
    end
  end

  task automatic do_write(input logic [2:0] a, input logic [15:0] d);
    addr = a; wdata = d; wr = 1'b1; t_wr = cyc;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] a);
    addr = a; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input int n, input int bound);
    int c = 0;
    while (done_cyc.size() < n && c < bound) begin
      @(negedge clk);
      c++;
    end
    if (done_cyc.size() < n) chk("done_timeout", 64'(done_cyc.size()), 64'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, n0;
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0;
    idle(3);
    rst_n = 1'b1;
    checking = 1;
    idle(1);
    chk("reset_seg", 64'(seg1), 64'h00000000FFFFFFFFC0);
    do_read(3'd5);
    chk("reset_status", 64'(rdata1), 64'h01);

    // basic conversion
    n0 = done_cyc.size();
    do_write(3'd0, 16'd12345); t0 = t_wr;
    wait_done(n0 + 1, 40);
    if (done_cyc.size() > n0) begin
      chk("basic_done_cycle", 64'(done_cyc[n0] - t0), 64'd18);
      chk("basic_seg", 64'(done_seg[n0]), 64'hF9A4B09992);
    end
    do_read(3'd2);
    chk("basic_rd2", 64'(rdata1), 64'h03);

    // leading-zero blanking
    n0 = done_cyc.size();
    do_write(3'd0, 16'd7);
    wait_done(n0 + 1, 40);
    idle(1);
    chk("blank_on", 64'(seg1), 64'hFFFFFFFFF8);
    do_write(3'd1, 16'd0);
    chk("blank_off", 64'(seg1), 64'hC0C0C0C0F8);
    do_write(3'd1, 16'd1);

    // overflow on the 4-digit instance
    n0 = done_cyc.size();
    do_write(3'd0, 16'd10000);
    wait_done(n0 + 1, 40);
    idle(1);
    chk("ovf_flag", 64'({ovf1, ovf2}), 64'b01);
    chk("ovf_seg", 64'(seg2), 64'hBFBFBFBF);
    do_read(3'd4);
    chk("ovf_status", 64'(rdata2), 64'h05);
    n0 = done_cyc.size();
    do_write(3'd0, 16'd9999);
    wait_done(n0 + 1, 40);
    idle(1);
    chk("max_flag", 64'(ovf2), 64'd0);
    chk("max_seg", 64'(seg2), 64'h90909090);

    // back-to-back writes chain without an idle cycle
    n0 = done_cyc.size();
    do_write(3'd0, 16'd100); t0 = t_wr;
    idle(2);
    do_write(3'd0, 16'd200);
    wait_done(n0 + 2, 60);
    if (done_cyc.size() > n0 + 1) begin
      chk("b2b_done0", 64'(done_cyc[n0] - t0), 64'd18);
      chk("b2b_done1", 64'(done_cyc[n0 + 1] - t0), 64'd35);
      chk("b2b_seg0", 64'(done_seg[n0]), 64'hFFFFF9C0C0);
      chk("b2b_seg1", 64'(done_seg[n0 + 1]), 64'hFFFFA4C0C0);
    end

    // pending overwrite: 300 is replaced by 400
    idle(2);
    n0 = done_cyc.size();
    do_write(3'd0, 16'd100);
    idle(2);
    do_write(3'd0, 16'd300);
    idle(2);
    do_write(3'd0, 16'd400);
    wait_done(n0 + 2, 80);
    idle(40);
    chk("pend_done_count", 64'(done_cyc.size() - n0), 64'd2);
    if (done_cyc.size() > n0 + 1) begin
      chk("pend_seg0", 64'(done_seg[n0]), 64'hFFFFF9C0C0);
      chk("pend_seg1", 64'(done_seg[n0 + 1]), 64'hFFFF99C0C0);
    end

    // reset during SHIFT cycle 5
    n0 = done_cyc.size();
    do_write(3'd0, 16'd555);
    idle(4);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    chk("rst_busy", 64'(busy1), 64'd0);
    chk("rst_seg", 64'(seg1), 64'hFFFFFFFFC0);
    do_read(3'd5);
    chk("rst_status", 64'(rdata1), 64'h01);
    idle(30);
    chk("rst_no_done", 64'(done_cyc.size()), 64'(n0));

    checking = 0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
